// File: rtl/noc_node_injector.sv
// Store-and-forward NOC injector: buffers one packet from the node, then emits
// head/body/tail flits to the local router port with a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for the first word of a packet
// COLLECT | accepting further words into the buffer
// HEAD    | presenting the head flit (dest, src, length)
// BODY    | presenting buffered words; the final one is typed as tail
module noc_node_injector #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 8,
  parameter int SRC_X     = 0,
  parameter int SRC_Y     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [1:0]        in_dest_x,
  input  logic [1:0]        in_dest_y,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [DATA_W+1:0] flit_data,
  output logic              ovf_pulse,
  output logic [15:0]       pkt_count
);

  localparam int         AW      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int         DEPTH   = 1 << AW;
  localparam logic [3:0] MAX_CNT = 4'(MAX_WORDS);
  localparam logic [1:0] SRC_X_L = 2'(SRC_X);
  localparam logic [1:0] SRC_Y_L = 2'(SRC_Y);

  typedef enum logic [1:0] {IDLE, COLLECT, HEAD, BODY} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q [DEPTH];
  logic [3:0]        cnt_q, rd_q, wr_idx, wr_cnt;
  logic [1:0]        dest_x_q, dest_y_q;
  logic              ovf_q;
  logic [15:0]       pkt_count_q;
  logic              in_fire, is_tail, last_word, ovf_set;
  logic [DATA_W-1:0] head_payload;

  always_comb begin
    in_ready   = (state_q == IDLE) || (state_q == COLLECT);
    flit_valid = (state_q == HEAD) || (state_q == BODY);
    in_fire    = in_valid && in_ready;
    // The first word always lands in slot 0, whatever the previous packet left in cnt_q.
    wr_idx     = (state_q == IDLE) ? 4'd0 : cnt_q;
    wr_cnt     = wr_idx + 4'd1;
    last_word  = in_last || (wr_cnt == MAX_CNT);
    ovf_set    = in_fire && !in_last && (wr_cnt == MAX_CNT);
    is_tail    = (rd_q == cnt_q - 4'd1);
    head_payload        = '0;
    head_payload[11:0]  = {dest_x_q, dest_y_q, SRC_X_L, SRC_Y_L, cnt_q};
    flit_data  = '0;
    state_d    = state_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (in_fire) state_d = last_word ? HEAD : COLLECT;
      end
      HEAD: begin
        flit_data = {2'b01, head_payload};
        if (flit_ready) state_d = BODY;
      end
      BODY: begin
        flit_data = {(is_tail ? 2'b10 : 2'b00), buf_q[rd_q[AW-1:0]]};
        if (flit_ready && is_tail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      dest_x_q    <= '0;
      dest_y_q    <= '0;
      ovf_q       <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_set;
      if (in_fire) begin
        cnt_q <= wr_cnt;
        if (state_q == IDLE) begin
          dest_x_q <= in_dest_x;
          dest_y_q <= in_dest_y;
        end
      end
      if (state_q == HEAD && flit_ready) rd_q <= '0;
      else if (state_q == BODY && flit_ready && !is_tail) rd_q <= rd_q + 4'd1;
      if (state_q == BODY && flit_ready && is_tail) pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  // Buffer contents need no reset; they are only read after being written.
  always_ff @(posedge clk) begin
    if (in_fire) buf_q[wr_idx[AW-1:0]] <= in_data;
  end

  assign ovf_pulse = ovf_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_noc_node_injector.sv
// Directed bench for noc_node_injector: one task per scenario, inline checks
// against hand-computed flit sequences.
module tb_noc_node_injector;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic [1:0]        in_dest_x = '0;
  logic [1:0]        in_dest_y = '0;
  logic              flit_valid;
  logic              flit_ready = 1'b0;
  logic [DATA_W+1:0] flit_data;
  logic              ovf_pulse;
  logic [15:0]       pkt_count;

  int n_cmp = 0;
  int n_mis = 0;

  noc_node_injector #(.DATA_W(DATA_W), .MAX_WORDS(8), .SRC_X(0), .SRC_Y(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .in_dest_x(in_dest_x), .in_dest_y(in_dest_y),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_data(flit_data),
    .ovf_pulse(ovf_pulse), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Head flit with this node at (0,0).
  function automatic logic [33:0] head(input logic [1:0] dx, input logic [1:0] dy,
                                       input logic [3:0] len);
    return {2'b01, 20'h0, dx, dy, 2'b00, 2'b00, len};
  endfunction

  // Presents n words base, base+1, ...; returns at the negedge after the last is accepted.
  task automatic drive_words(input int n, input logic [DATA_W-1:0] base,
                             input logic [1:0] dx, input logic [1:0] dy,
                             input bit last_on_final, input bit flip_dest);
    for (int i = 0; i < n; i++) begin
      int w;
      in_valid  = 1'b1;
      in_data   = base + DATA_W'(i);
      in_last   = last_on_final && (i == n - 1);
      in_dest_x = (flip_dest && i > 0) ? ~dx : dx;
      in_dest_y = (flip_dest && i > 0) ? ~dy : dy;
      w = 0;
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) begin
        n_mis++;
        $display("FAIL drive_timeout: in_ready stuck at %b, required 1", in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    n_cmp++; if (flit_valid !== 1'b0) begin n_mis++; $display("FAIL rst_flit_valid: got %b exp 0", flit_valid); end
    n_cmp++; if (flit_data !== 34'h0) begin n_mis++; $display("FAIL rst_flit_data: got %h exp 0", flit_data); end
    n_cmp++; if (ovf_pulse !== 1'b0) begin n_mis++; $display("FAIL rst_ovf: got %b exp 0", ovf_pulse); end
    n_cmp++; if (pkt_count !== 16'h0) begin n_mis++; $display("FAIL rst_pkt_count: got %h exp 0", pkt_count); end
  endtask

  task automatic test_three_word();
    logic [33:0] exp [4];
    exp[0] = head(2'd2, 2'd1, 4'd3);
    exp[1] = {2'b00, 32'hA000_0000};
    exp[2] = {2'b00, 32'hA000_0001};
    exp[3] = {2'b10, 32'hA000_0002};
    flit_ready = 1'b1;
    drive_words(3, 32'hA000_0000, 2'd2, 2'd1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (flit_valid !== 1'b1 || flit_data !== exp[k]) begin
        n_mis++;
        $display("FAIL three_flit%0d: got v=%b %h exp v=1 %h", k, flit_valid, flit_data, exp[k]);
      end
      n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL three_in_ready%0d: got %b exp 0", k, in_ready); end
      @(negedge clk);
    end
    n_cmp++; if (flit_valid !== 1'b0) begin n_mis++; $display("FAIL three_done_valid: got %b exp 0", flit_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL three_done_ready: got %b exp 1", in_ready); end
    n_cmp++; if (pkt_count !== 16'd1) begin n_mis++; $display("FAIL three_pkt_count: got %0d exp 1", pkt_count); end
  endtask

  task automatic test_single_word();
    logic [33:0] exp [2];
    exp[0] = head(2'd3, 2'd3, 4'd1);
    exp[1] = {2'b10, 32'h0000_DEAD};
    flit_ready = 1'b1;
    drive_words(1, 32'h0000_DEAD, 2'd3, 2'd3, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (flit_valid !== 1'b1 || flit_data !== exp[k]) begin
        n_mis++;
        $display("FAIL single_flit%0d: got v=%b %h exp v=1 %h", k, flit_valid, flit_data, exp[k]);
      end
      @(negedge clk);
    end
    n_cmp++; if (flit_valid !== 1'b0) begin n_mis++; $display("FAIL single_extra_flit: got v=%b exp 0", flit_valid); end
    n_cmp++; if (pkt_count !== 16'd2) begin n_mis++; $display("FAIL single_pkt_count: got %0d exp 2", pkt_count); end
  endtask

  task automatic test_overflow();
    logic [33:0] exp [12];
    int k, cyc, ovf_cnt;
    exp[0] = head(2'd1, 2'd2, 4'd8);
    for (int i = 0; i < 7; i++) exp[1 + i] = {2'b00, 32'h100 + 32'(i)};
    exp[8]  = {2'b10, 32'h107};
    exp[9]  = head(2'd1, 2'd2, 4'd2);
    exp[10] = {2'b00, 32'h108};
    exp[11] = {2'b10, 32'h109};
    flit_ready = 1'b1;
    k = 0; cyc = 0; ovf_cnt = 0;
    fork
      drive_words(10, 32'h100, 2'd1, 2'd2, 1'b1, 1'b0);
      begin
        while (k < 12 && cyc < 300) begin
          if (ovf_pulse) ovf_cnt++;
          if (flit_valid) begin
            n_cmp++;
            if (flit_data !== exp[k]) begin
              n_mis++;
              $display("FAIL ovf_flit%0d: got %h exp %h", k, flit_data, exp[k]);
            end
            if (k == 0) begin
              n_cmp++; if (ovf_pulse !== 1'b1) begin n_mis++; $display("FAIL ovf_pulse_timing: got %b exp 1", ovf_pulse); end
            end
            k++;
          end
          @(negedge clk);
          cyc++;
        end
      end
    join
    n_cmp++; if (k != 12) begin n_mis++; $display("FAIL ovf_timeout: got %0d flits exp 12", k); end
    n_cmp++; if (ovf_cnt != 1) begin n_mis++; $display("FAIL ovf_pulse_count: got %0d exp 1", ovf_cnt); end
    n_cmp++; if (pkt_count !== 16'd4) begin n_mis++; $display("FAIL ovf_pkt_count: got %0d exp 4", pkt_count); end
  endtask

  task automatic test_backpressure();
    logic [33:0] exp [5];
    int k, cyc, stalls;
    exp[0] = head(2'd0, 2'd3, 4'd4);
    exp[1] = {2'b00, 32'h300};
    exp[2] = {2'b00, 32'h301};
    exp[3] = {2'b00, 32'h302};
    exp[4] = {2'b10, 32'h303};
    flit_ready = 1'b0;
    k = 0; cyc = 0; stalls = 0;
    fork
      drive_words(4, 32'h300, 2'd0, 2'd3, 1'b1, 1'b0);
      begin
        while (k < 5 && cyc < 400) begin
          flit_ready = 1'($urandom_range(0, 1));
          if (flit_valid) begin
            n_cmp++;
            if (flit_data !== exp[k]) begin
              n_mis++;
              $display("FAIL bp_flit%0d: got %h exp %h", k, flit_data, exp[k]);
            end
            n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
            if (flit_ready) k++;
            else stalls++;
          end else if (k > 0) begin
            n_cmp++; n_mis++;
            $display("FAIL bp_valid_drop: got flit_valid 0 exp 1 at flit %0d", k);
          end
          @(negedge clk);
          cyc++;
        end
      end
    join
    flit_ready = 1'b1;
    n_cmp++; if (k != 5) begin n_mis++; $display("FAIL bp_timeout: got %0d flits exp 5", k); end
    n_cmp++; if (pkt_count !== 16'd5) begin n_mis++; $display("FAIL bp_pkt_count: got %0d exp 5", pkt_count); end
    if (stalls == 0) $display("note: backpressure run saw no stall cycles");
  endtask

  task automatic test_reset_mid_body();
    logic [33:0] exp [3];
    flit_ready = 1'b1;
    drive_words(4, 32'h400, 2'd3, 2'd0, 1'b1, 1'b0);
    n_cmp++; if (flit_data !== head(2'd3, 2'd0, 4'd4)) begin n_mis++; $display("FAIL mid_head: got %h exp %h", flit_data, head(2'd3, 2'd0, 4'd4)); end
    @(negedge clk);
    n_cmp++; if (flit_data !== {2'b00, 32'h400}) begin n_mis++; $display("FAIL mid_body0: got %h exp %h", flit_data, {2'b00, 32'h400}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (flit_valid !== 1'b0) begin n_mis++; $display("FAIL mid_rst_valid: got %b exp 0", flit_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL mid_rst_ready: got %b exp 1", in_ready); end
    n_cmp++; if (pkt_count !== 16'd0) begin n_mis++; $display("FAIL mid_rst_count: got %0d exp 0", pkt_count); end
    exp[0] = head(2'd1, 2'd1, 4'd2);
    exp[1] = {2'b00, 32'h500};
    exp[2] = {2'b10, 32'h501};
    drive_words(2, 32'h500, 2'd1, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (flit_valid !== 1'b1 || flit_data !== exp[k]) begin
        n_mis++;
        $display("FAIL post_rst_flit%0d: got v=%b %h exp v=1 %h", k, flit_valid, flit_data, exp[k]);
      end
      @(negedge clk);
    end
    n_cmp++; if (pkt_count !== 16'd1) begin n_mis++; $display("FAIL post_rst_count: got %0d exp 1", pkt_count); end
  endtask

  task automatic test_count_wrap();
    logic [15:0] exp_cnt [3];
    exp_cnt[0] = 16'hFFFF;
    exp_cnt[1] = 16'h0000;
    exp_cnt[2] = 16'h0001;
    flit_ready = 1'b1;
    // Preload the counter near wrap instead of sending 65534 packets.
    force dut.pkt_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.pkt_count_q;
    @(negedge clk);
    n_cmp++; if (pkt_count !== 16'hFFFE) begin n_mis++; $display("FAIL wrap_preload: got %h exp fffe", pkt_count); end
    for (int i = 0; i < 3; i++) begin
      drive_words(1, 32'h600 + 32'(i), 2'd0, 2'd0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (pkt_count !== exp_cnt[i]) begin
        n_mis++;
        $display("FAIL wrap_count%0d: got %h exp %h", i, pkt_count, exp_cnt[i]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_three_word();
    test_single_word();
    test_overflow();
    test_backpressure();
    test_reset_mid_body();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
